// File: rtl/gru_seq_ctrl.sv
// Sequencing controller for a two-lane GRU datapath: walks a sequence of input
// samples, feeds x/h to the datapath, collects h_t and hands it to a consumer.
module gru_seq_ctrl #(
    parameter int WIDTH       = 17,
    parameter int LEN_W       = 8,
    parameter int GRU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] seq_len,
    input  logic [WIDTH-1:0] h_init0,
    input  logic [WIDTH-1:0] h_init1,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] gru_x0,
    output logic [WIDTH-1:0] gru_x1,
    output logic [WIDTH-1:0] gru_h0,
    output logic [WIDTH-1:0] gru_h1,
    input  logic [WIDTH-1:0] gru_y0,
    input  logic [WIDTH-1:0] gru_y1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_h0,
    output logic [WIDTH-1:0] out_h1,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_X  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int             LAT_W    = 4;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(GRU_LATENCY);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] step_q, step_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [WIDTH-1:0] h0_q, h0_d, h1_q, h1_d;

    logic [LEN_W-1:0] len_m1;
    logic             last_step;

    // Last step is step == len-1; len == 0 never reaches EMIT, so the wrap is harmless.
    assign len_m1    = len_q - LEN_W'(1);
    assign last_step = (step_q == len_m1);

    always_comb begin
        // NOTE: every next-state variable gets a hold default first so no branch infers a latch.
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        lat_d   = lat_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        h0_d    = h0_q;
        h1_d    = h1_q;

        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_d   = seq_len;
                        h0_d    = h_init0;
                        h1_d    = h_init1;
                        step_d  = '0;
                        lat_d   = '0;
                        state_d = (seq_len != '0) ? S_WAIT_X : S_DONE;
                    end
                end
                S_WAIT_X: begin
                    if (x_valid) begin
                        x0_d    = x0;
                        x1_d    = x1;
                        lat_d   = '0;
                        state_d = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (lat_q == LAT_LAST) begin
                        h0_d    = gru_y0;
                        h1_d    = gru_y1;
                        state_d = S_EMIT;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (last_step) begin
                            state_d = S_DONE;
                        end else begin
                            step_d  = step_q + LEN_W'(1);
                            state_d = S_WAIT_X;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            step_q  <= '0;
            lat_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            h0_q    <= '0;
            h1_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            step_q  <= step_d;
            lat_q   <= lat_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
        end
    end

    assign x_ready   = (state_q == S_WAIT_X);
    assign out_valid = (state_q == S_EMIT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_last  = last_step;

    assign gru_x0 = x0_q;
    assign gru_x1 = x1_q;
    assign gru_h0 = h0_q;
    assign gru_h1 = h1_q;
    assign out_h0 = h0_q;
    assign out_h1 = h1_q;

endmodule
